imem_fetch_ctrl: RTL and testbench

//  Instruction-memory controller directly upstream of the IF stage.
//  - Takes the IF next-PC each cycle.
//  - Issues one word fetch at a time on a req/gnt/rvalid instruction bus.
//  - Returns the word to IF as instr_read_data_valid / instr_read_data, only when it belongs to IF's current pc.
//  - Drops stale responses after redirects. Reports bus errors and timeouts to trap control.

---
 rtl/imem_fetch_ctrl.sv | 80 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: single-outstanding instruction fetch between IF and the imem bus,
// delivering only words that match IF's current pc and trapping on bus errors/timeouts.
module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]  boot_addr,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    output logic                   instr_bus_err,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_err
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [CW-1:0]           cnt;
    logic                    hit;
    logic                    deliver;
    assign hit                   = req_addr == pc_q;
    assign deliver               = state == WAIT && imem_rvalid && hit && !imem_err;
    assign instr_read_data_valid = deliver;
    assign instr_read_data       = deliver ? imem_rdata : '0;
    assign imem_addr             = req_addr;
    // The counter leaves WAIT at TIMEOUT_CYC-1, so it can never wrap.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state         <= IDLE;
            pc_q          <= boot_addr;
            req_addr      <= boot_addr;
            imem_req      <= 1'b0;
            instr_bus_err <= 1'b0;
            cnt           <= '0;
        end else begin
            pc_q <= next_pc;
            case (state)
                IDLE: begin
                    req_addr <= next_pc;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: if (imem_gnt) begin
                    imem_req <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: if (imem_rvalid && hit && imem_err) begin
                    instr_bus_err <= 1'b1;
                    state         <= ERR;
                end else if (imem_rvalid) begin
                    req_addr <= next_pc;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    instr_bus_err <= 1'b1;
                    state         <= ERR;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ERR: if (next_pc != pc_q) begin
                    req_addr      <= next_pc;
                    instr_bus_err <= 1'b0;
                    imem_req      <= 1'b1;
                    state         <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the fetch controller.
module tb_imem_fetch_ctrl;
    localparam int TO = 8;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_ERR = 3;
    logic        cpu_clk, cpu_rstn;
    logic [31:0] boot_addr, next_pc;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        instr_bus_err, imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid, imem_err;
    logic [31:0] imem_rdata;
    int          n_tests = 0;
    int          n_fail = 0;

    imem_fetch_ctrl #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .boot_addr(boot_addr), .next_pc(next_pc),
        .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
        .instr_bus_err(instr_bus_err), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] b);
        cpu_rstn = 1'b0; boot_addr = b; next_pc = b;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0;
        tick(); tick();
        cpu_rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(32'h1000);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data, instr_bus_err, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h1000}) begin
            n_fail++;
            $display("FAIL reset_state got v=%b d=%h e=%b r=%b a=%h exp 0/0/0/0/1000", instr_read_data_valid, instr_read_data, instr_bus_err, imem_req, imem_addr);
        end
        imem_rvalid = 1'b0;
        tick();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h1000}) begin
            n_fail++;
            $display("FAIL reset_first_req got r=%b a=%h exp 1/1000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            imem_rvalid = 1'b0; #1;
            n_tests++;
            if ({imem_req, imem_addr, instr_read_data_valid} !== {1'b1, 32'(4 * k), 1'b0}) begin
                n_fail++;
                $display("FAIL stream_req k=%0d got r=%b a=%h v=%b exp 1/%h/0", k, imem_req, imem_addr, instr_read_data_valid, 4 * k);
            end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'(4 * k)); #1;
            n_tests++;
            if ({imem_req, instr_read_data_valid, instr_read_data} !== {1'b0, 1'b1, mem(32'(4 * k))}) begin
                n_fail++;
                $display("FAIL stream_data k=%0d got r=%b v=%b d=%h exp 0/1/%h", k, imem_req, instr_read_data_valid, instr_read_data, mem(32'(4 * k)));
            end
            next_pc = 32'(4 * k + 4);
        end
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_gnt_stall();
        do_reset(32'h8);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) next_pc = 32'h100;
            #1;
            n_tests++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d got r=%b a=%h exp 1/8", i, imem_req, imem_addr);
            end
            tick();
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h8); #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL stall_drop got v=%b d=%h exp 0/0", instr_read_data_valid, instr_read_data);
        end
        tick();
        imem_rvalid = 1'b0; #1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL stall_next_req got r=%b a=%h exp 1/100", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h100); #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data} !== {1'b1, mem(32'h100)}) begin
            n_fail++;
            $display("FAIL stall_deliver got v=%b d=%h exp 1/%h", instr_read_data_valid, instr_read_data, mem(32'h100));
        end
        next_pc = 32'h104;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset(32'hC);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; next_pc = 32'h200;
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem(32'hC); #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL redirect_stale got v=%b d=%h exp 0/0", instr_read_data_valid, instr_read_data);
        end
        tick();
        imem_rvalid = 1'b0; #1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL redirect_req got r=%b a=%h exp 1/200", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h200); next_pc = 32'h300; #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data} !== {1'b1, mem(32'h200)}) begin
            n_fail++;
            $display("FAIL redirect_same_cycle_hit got v=%b d=%h exp 1/%h", instr_read_data_valid, instr_read_data, mem(32'h200));
        end
        tick();
        imem_rvalid = 1'b0; #1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL redirect_new_req got r=%b a=%h exp 1/300", imem_req, imem_addr);
        end
    endtask

    task automatic test_bus_err();
        do_reset(32'h10);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = mem(32'h10); #1;
        n_tests++;
        if ({instr_read_data_valid, instr_bus_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_resp got v=%b e=%b exp 0/0", instr_read_data_valid, instr_bus_err);
        end
        tick();
        imem_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = mem(32'h10); #1;
            n_tests++;
            if ({instr_read_data_valid, instr_bus_err, imem_req} !== 3'b010) begin
                n_fail++;
                $display("FAIL err_hold i=%0d got v=%b e=%b r=%b exp 0/1/0", i, instr_read_data_valid, instr_bus_err, imem_req);
            end
            tick();
        end
        imem_rvalid = 1'b0; next_pc = 32'h80;
        tick();
        n_tests++;
        if ({instr_bus_err, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL err_exit got e=%b r=%b a=%h exp 0/1/80", instr_bus_err, imem_req, imem_addr);
        end
    endtask

    task automatic test_timeout();
        do_reset(32'h40);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            n_tests++;
            if (instr_bus_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early i=%0d got e=%b exp 0", i, instr_bus_err);
            end
        end
        tick();
        n_tests++;
        if ({instr_bus_err, imem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_rise got e=%b r=%b exp 1/0", instr_bus_err, imem_req);
        end
        imem_rvalid = 1'b1; imem_rdata = mem(32'h40); #1;
        n_tests++;
        if ({instr_read_data_valid, instr_read_data} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_late_rvalid got v=%b d=%h exp 0/0", instr_read_data_valid, instr_read_data);
        end
        tick();
        imem_rvalid = 1'b0;
        n_tests++;
        if ({instr_bus_err, imem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_hold got e=%b r=%b exp 1/0", instr_bus_err, imem_req);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(32'h20);
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; boot_addr = 32'h400; next_pc = 32'h400; cpu_rstn = 1'b0; #1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h400}) begin
            n_fail++;
            $display("FAIL reset_mid_async got r=%b a=%h exp 0/400", imem_req, imem_addr);
        end
        tick();
        cpu_rstn = 1'b1; imem_rvalid = 1'b1; imem_rdata = mem(32'h20); #1;
        n_tests++;
        if (instr_read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rvalid got v=%b exp 0", instr_read_data_valid);
        end
        tick();
        imem_rvalid = 1'b0;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h400}) begin
            n_fail++;
            $display("FAIL reset_mid_first_req got r=%b a=%h exp 1/400", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, addr, nxt;
        logic        err_lvl, exp_v;
        int          ph, waited;
        do_reset(32'h100);
        pc = 32'h100; addr = 32'h100; ph = PH_IDLE; waited = 0; err_lvl = 1'b0;
        for (int c = 0; c < 600; c++) begin
            imem_gnt    = $urandom_range(0, 2) != 0;
            imem_rvalid = $urandom_range(0, 2) == 0;
            imem_err    = $urandom_range(0, 7) == 0;
            imem_rdata  = $urandom;
            #1;
            exp_v = ph == PH_WAIT && imem_rvalid && !imem_err && addr == pc;
            n_tests++;
            if ({instr_read_data_valid, instr_read_data, instr_bus_err, imem_req, imem_addr} !==
                {exp_v, exp_v ? imem_rdata : 32'h0, err_lvl, ph == PH_REQ, addr}) begin
                n_fail++;
                $display("FAIL random c=%0d got v=%b d=%h e=%b r=%b a=%h exp %b/%h/%b/%b/%h", c,
                         instr_read_data_valid, instr_read_data, instr_bus_err, imem_req, imem_addr,
                         exp_v, exp_v ? imem_rdata : 32'h0, err_lvl, ph == PH_REQ, addr);
            end
            nxt = exp_v ? pc + 32'h4 : pc;
            if ($urandom_range(0, 9) == 0) nxt = 32'($urandom_range(0, 4095));
            next_pc = nxt;
            if (ph == PH_IDLE) begin
                addr = nxt; ph = PH_REQ;
            end else if (ph == PH_REQ) begin
                if (imem_gnt) begin ph = PH_WAIT; waited = 0; end
            end else if (ph == PH_WAIT) begin
                if (imem_rvalid && imem_err && addr == pc) begin ph = PH_ERR; err_lvl = 1'b1; end
                else if (imem_rvalid) begin addr = nxt; ph = PH_REQ; end
                else if (waited == TO - 1) begin ph = PH_ERR; err_lvl = 1'b1; end
                else waited++;
            end else if (nxt != pc) begin
                addr = nxt; err_lvl = 1'b0; ph = PH_REQ;
            end
            pc = nxt;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gnt_stall();
        test_redirect();
        test_bus_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
